// File: rtl/clk_presc.sv
`default_nettype none
// ============================================================================
// Module   : clk_presc
// Purpose  : Programmable clock prescaler. Produces a 50% duty divided clock
//            with period 2*N input clocks, plus a one-cycle strobe that marks
//            every rising edge of the divided clock.
// Ports    : clk       - system clock, all state changes on rising edge
//            rst_n     - asynchronous active-low reset
//            pres      - divide ratio N (0 disables, output parked low)
//            pres_clk  - divided clock, straight from a flip-flop
//            pres_tick - one-cycle strobe, high the cycle pres_clk becomes 1
// Revision : 1.0 - initial release
// ============================================================================
module clk_presc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pres,
  output logic             pres_clk,
  output logic             pres_tick
);

  localparam logic [WIDTH:0] c_ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt;
  logic             r_clk;
  logic             r_tick;

  logic             w_en;
  logic [WIDTH:0]   w_cnt_inc;
  logic             w_wrap;

  assign w_en      = (pres != '0);
  // One extra bit so that cnt >= pres-1 is evaluated as cnt+1 >= pres:
  // no subtraction, hence no wrap for pres=0 and no overflow at the maximum
  // ratio. A ratio lowered below the current count wraps on the next edge.
  assign w_cnt_inc = {1'b0, r_cnt} + c_ONE;
  assign w_wrap    = (w_cnt_inc >= {1'b0, pres});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (!w_en) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_clk  <= ~r_clk;
      // Strobe only on the low-to-high half of the toggle.
      r_tick <= ~r_clk;
    end else begin
      r_cnt  <= w_cnt_inc[WIDTH-1:0];
      r_tick <= 1'b0;
    end
  end

  assign pres_clk  = r_clk;
  assign pres_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clk_presc.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_presc
// Purpose  : Self-checking bench for clk_presc. A per-edge vector table covers
//            the short ratios (1..4, disable), hand sequences cover the long
//            ratio, reset mid-period, ratio change mid-period and the maximum
//            ratio of a narrow instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_presc;

  logic        clk;
  logic        rst_n;
  logic [31:0] pres;
  logic        pres_clk;
  logic        pres_tick;

  logic [3:0]  pres_s;
  logic        pres_clk_s;
  logic        pres_tick_s;

  int n_cmp;
  int n_err;

  clk_presc #(.WIDTH(32)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pres      (pres),
    .pres_clk  (pres_clk),
    .pres_tick (pres_tick)
  );

  clk_presc #(.WIDTH(4)) u_dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .pres      (pres_s),
    .pres_clk  (pres_clk_s),
    .pres_tick (pres_tick_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pres;
    logic        exp_clk;
    logic        exp_tick;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance n rising edges, leaving the time 1 unit after the last edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check outputs clear at once, hold a few edges,
  // release 1 unit after an edge so the next edge is edge 1.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    chk({nm, "_rst_clk_async"}, int'(pres_clk), 0);
    chk({nm, "_rst_tick_async"}, int'(pres_tick), 0);
    edges(3);
    chk({nm, "_rst_clk_hold"}, int'(pres_clk), 0);
    rst_n = 1'b1;
  endtask

  // Count edges until pres_clk reaches level lvl; bounded by limit.
  task automatic wait_lvl(input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      edges(1);
      n++;
    end while (pres_clk !== lvl && n < limit);
  endtask

  task automatic wait_lvl_s(input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      edges(1);
      n++;
    end while (pres_clk_s !== lvl && n < limit);
  endtask

  initial begin
    int n;
    int pulses;
    int wide;
    logic prev;

    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    pres   = 32'd4;
    pres_s = 4'd0;

    // Per-edge table starting right after reset release with pres=4.
    vt[0]  = '{32'd4, 1'b0, 1'b0};
    vt[1]  = '{32'd4, 1'b0, 1'b0};
    vt[2]  = '{32'd4, 1'b0, 1'b0};
    vt[3]  = '{32'd4, 1'b1, 1'b1};
    vt[4]  = '{32'd4, 1'b1, 1'b0};
    vt[5]  = '{32'd4, 1'b1, 1'b0};
    vt[6]  = '{32'd4, 1'b1, 1'b0};
    vt[7]  = '{32'd4, 1'b0, 1'b0};
    vt[8]  = '{32'd1, 1'b1, 1'b1};
    vt[9]  = '{32'd1, 1'b0, 1'b0};
    vt[10] = '{32'd1, 1'b1, 1'b1};
    vt[11] = '{32'd0, 1'b0, 1'b0};
    vt[12] = '{32'd0, 1'b0, 1'b0};
    vt[13] = '{32'd2, 1'b0, 1'b0};
    vt[14] = '{32'd2, 1'b1, 1'b1};
    vt[15] = '{32'd2, 1'b1, 1'b0};
    vt[16] = '{32'd2, 1'b0, 1'b0};
    vt[17] = '{32'd3, 1'b0, 1'b0};
    vt[18] = '{32'd3, 1'b0, 1'b0};
    vt[19] = '{32'd3, 1'b1, 1'b1};

    edges(2);
    chk("reset_clk", int'(pres_clk), 0);
    chk("reset_tick", int'(pres_tick), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      pres = vt[i].pres;
      edges(1);
      chk($sformatf("vec%0d_clk", i), int'(pres_clk), int'(vt[i].exp_clk));
      chk($sformatf("vec%0d_tick", i), int'(pres_tick), int'(vt[i].exp_tick));
    end

    // Disable after running at 4, then restore: rise 4 edges later.
    pres = 32'd4;
    do_reset("dis");
    edges(5);
    pres = 32'd0;
    edges(1);
    chk("dis_clk", int'(pres_clk), 0);
    chk("dis_tick", int'(pres_tick), 0);
    pres = 32'd4;
    wait_lvl(1'b1, 20, n);
    chk("dis_restore_rise", n, 4);

    // Long ratio: rise at edge 78, fall at edge 156.
    pres = 32'd78;
    do_reset("p78");
    wait_lvl(1'b1, 200, n);
    chk("p78_rise_edge", n, 78);
    chk("p78_rise_tick", int'(pres_tick), 1);
    wait_lvl(1'b0, 200, n);
    chk("p78_fall_edge", n + 78, 156);
    chk("p78_fall_tick", int'(pres_tick), 0);

    // Tick pulses over 1560 cycles: exactly 10, each one cycle wide.
    do_reset("cnt");
    pulses = 0;
    wide   = 0;
    prev   = 1'b0;
    for (int i = 0; i < 1560; i++) begin
      edges(1);
      if (pres_tick === 1'b1 && prev !== 1'b1) pulses++;
      if (pres_tick === 1'b1 && prev === 1'b1) wide++;
      prev = pres_tick;
    end
    chk("tick_pulses", pulses, 10);
    chk("tick_wide", wide, 0);

    // Reset mid-period at edge 100 (output high), then full restart.
    do_reset("mid");
    edges(100);
    chk("mid_clk_before", int'(pres_clk), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_clk_async", int'(pres_clk), 0);
    chk("mid_tick_async", int'(pres_tick), 0);
    edges(2);
    rst_n = 1'b1;
    wait_lvl(1'b1, 200, n);
    chk("mid_restart_rise", n, 78);

    // Ratio 10, count at 7, lower to 5: toggle on next edge, then period 10.
    pres = 32'd10;
    do_reset("chg");
    edges(7);
    chk("chg_clk_pre", int'(pres_clk), 0);
    pres = 32'd5;
    edges(1);
    chk("chg_clk_toggle", int'(pres_clk), 1);
    chk("chg_tick_toggle", int'(pres_tick), 1);
    wait_lvl(1'b0, 50, n);
    chk("chg_fall", n, 5);
    wait_lvl(1'b1, 50, n);
    chk("chg_rise", n, 5);

    // Maximum ratio on the 4-bit instance: 15 edges per half period.
    pres_s = 4'd15;
    do_reset("max");
    wait_lvl_s(1'b1, 40, n);
    chk("max_rise", n, 15);
    chk("max_tick", int'(pres_tick_s), 1);
    wait_lvl_s(1'b0, 40, n);
    chk("max_fall", n, 15);
    wait_lvl_s(1'b1, 40, n);
    chk("max_rise2", n, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
